// File: rtl/sram_fifo_pkg.sv
// Shared constants and pointer-wrap helper for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  localparam int unsigned PREFETCH_DEPTH = 3;
  localparam int unsigned BUF_IDX_W      = 2;
  localparam int unsigned BUF_CNT_W      = 2;

  // Wraps at depth-1 explicitly so non-power-of-2 depths work.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sram_fifo_prefetch_buf.sv
// Small register queue that absorbs SRAM read data so the dequeue side sees zero latency.
module sram_fifo_prefetch_buf
  import sram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [BUF_CNT_W-1:0]  cnt,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] entries [PREFETCH_DEPTH];
  logic [BUF_IDX_W-1:0]  head;
  logic [BUF_IDX_W-1:0]  tail;

  // Flush returns the queue to its reset image, including cleared entries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < int'(PREFETCH_DEPTH); i++) entries[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < int'(PREFETCH_DEPTH); i++) entries[i] <= '0;
    end else begin
      if (push) begin
        entries[tail] <= push_data;
        tail          <= BUF_IDX_W'(next_ptr(32'(tail), PREFETCH_DEPTH));
      end
      if (pop) head <= BUF_IDX_W'(next_ptr(32'(head), PREFETCH_DEPTH));
      cnt <= cnt + BUF_CNT_W'(push) - BUF_CNT_W'(pop);
    end
  end

  assign head_data = entries[head];

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving a 1R1W SRAM, hiding its read latency behind a prefetch buffer.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 4)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [DATA_WIDTH-1:0] enq_bits,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [DATA_WIDTH-1:0] deq_bits,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  mem_wr_enable,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_dataIn,
  output logic                  mem_rd_enable,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_dataOut
);

  localparam int unsigned SCNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [SCNT_W-1:0]     sram_cnt;
  logic                  inflight;
  logic [BUF_CNT_W-1:0]  buf_cnt;
  logic                  enq_fire;
  logic                  rd_issue;
  logic                  deq_fire;

  // Only registered state feeds the read strobe, so deq_ready/enq_valid never reach mem_rd_*.
  assign enq_ready = ~reset & ~flush & (sram_cnt < SCNT_W'(DEPTH));
  assign enq_fire  = enq_valid & enq_ready;
  assign rd_issue  = ~flush & (sram_cnt != '0)
                   & ((3'(buf_cnt) + 3'(inflight)) < 3'(PREFETCH_DEPTH));
  assign deq_valid = (buf_cnt != '0);
  assign deq_fire  = deq_valid & deq_ready & ~flush;
  assign count     = CNT_WIDTH'(sram_cnt) + CNT_WIDTH'(inflight) + CNT_WIDTH'(buf_cnt);

  assign mem_wr_enable = enq_fire;
  assign mem_wr_addr   = wr_ptr;
  assign mem_wr_dataIn = enq_bits;
  assign mem_rd_enable = rd_issue;
  assign mem_rd_addr   = rd_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      if (enq_fire) wr_ptr <= ADDR_WIDTH'(next_ptr(32'(wr_ptr), DEPTH));
      if (rd_issue) rd_ptr <= ADDR_WIDTH'(next_ptr(32'(rd_ptr), DEPTH));
      sram_cnt <= sram_cnt + SCNT_W'(enq_fire) - SCNT_W'(rd_issue);
      inflight <= rd_issue;
    end
  end

  // A read returning while flush is high is dropped by the buffer's flush priority.
  sram_fifo_prefetch_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_prefetch_buf (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (inflight),
    .push_data (mem_rd_dataOut),
    .pop       (deq_fire),
    .cnt       (buf_cnt),
    .head_data (deq_bits)
  );

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Synchronous FIFO controller that drives an external 1-read/1-write SRAM wrapper, the initiator side of its wr_*/rd_* port pair. Accepts a valid/ready enqueue stream, stores entries in the SRAM, and issues reads. It hides the SRAM's 1-cycle read latency behind a 3-entry prefetch buffer, so a valid/ready dequeue stream sustains 1 entry/cycle. Sits between stream producers/consumers and any Sram1r1wWrapper instance, with both wrapper clocks tied to this block's clock.

Parameters:
DEPTH, 512, SRAM entries; any integer >= 2, not necessarily a power of 2
DATA_WIDTH, 32, entry width in bits
ADDR_WIDTH, $clog2(DEPTH), SRAM address width
CNT_WIDTH, $clog2(DEPTH+4), width of the occupancy count (max DEPTH+3)

Ports:
clock  in  1  single clock; the SRAM wr_clock and rd_clock connect to the same net
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all contents
enq_valid  in  1  producer has data
enq_ready  out  1  FIFO can accept
enq_bits  in  DATA_WIDTH  enqueue data
deq_valid  out  1  head entry available
deq_ready  in  1  consumer takes head
deq_bits  out  DATA_WIDTH  head entry, registered
count  out  CNT_WIDTH  total entries held: SRAM + in-flight read + buffer
mem_wr_enable  out  1  SRAM write strobe
mem_wr_addr  out  ADDR_WIDTH  SRAM write address
mem_wr_dataIn  out  DATA_WIDTH  SRAM write data
mem_rd_enable  out  1  SRAM read strobe
mem_rd_addr  out  ADDR_WIDTH  SRAM read address
mem_rd_dataOut  in  DATA_WIDTH  SRAM read data, valid the cycle after mem_rd_enable

Behaviour:
- State: wr_ptr, rd_ptr (ADDR_WIDTH), sram_cnt (0..DEPTH), inflight (1 bit), buf[3] with head/tail indices and buf_cnt (0..3).
- Reset (async): pointers, counts, inflight and buf_cnt clear to 0. deq_valid=0, deq_bits=0, count=0, mem_wr_enable=0, mem_rd_enable=0.
- enq_ready = (sram_cnt < DEPTH) & ~flush. It is combinational from registered state only.
- enq_fire = enq_valid & enq_ready. The write is driven in the same cycle: mem_wr_enable=enq_fire, mem_wr_addr=wr_ptr, mem_wr_dataIn=enq_bits.
- Read issue: rd_issue = (sram_cnt != 0) & (buf_cnt + inflight < 3) & ~flush.
  - Uses registered state only. There is no combinational path from deq_ready or enq_valid to the mem_rd_* ports.
  - mem_rd_enable=rd_issue, mem_rd_addr=rd_ptr.
- Read-during-write hazard: a read targets only entries counted in the registered sram_cnt. Those were written on an earlier edge, so the same address is never read and written in one cycle.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. Plain increment is not used, because DEPTH may be a non-power-of-2.
- sram_cnt next = sram_cnt + enq_fire - rd_issue. Simultaneous enq and read leave it unchanged.
- inflight next = rd_issue. When inflight=1, mem_rd_dataOut is pushed into buf at the tail.
- deq_valid = (buf_cnt != 0). deq_bits = buf[head]. deq_fire = deq_valid & deq_ready pops the head.
  - buf_cnt next = buf_cnt + inflight - deq_fire.
  - A push and a pop in the same cycle are both honoured.
- Overflow safety: buf_cnt + inflight <= 3 always holds, so a push never overflows buf.
- Latency: an enq in cycle N gives deq_valid in cycle N+3 when the FIFO is empty. Write at edge N, read issued in N+1, data captured at the end of N+2.
- Throughput: 1 entry/cycle sustained when deq_ready is held high.
- count = sram_cnt + inflight + buf_cnt. Full capacity is DEPTH+3: enq_ready stays 1 until the SRAM itself holds DEPTH entries.
- flush (sync): the next state equals the reset state.
  - enq_ready=0, mem_wr_enable=0, mem_rd_enable=0 during the flush cycle.
  - A read already in flight is discarded: inflight clears, no push.
  - deq_fire in the flush cycle is ignored.
- Reset mid-operation: all state clears immediately. SRAM contents are don't-care.

Decomposition:
- Package sram_fifo_pkg: PREFETCH_DEPTH=3 constant, and a function next_ptr(ptr, depth) implementing the wrap rule.
- Sub-module sram_fifo_prefetch_buf: the 3-entry register queue with push/pop/cnt/head data.
- sram_fifo_ctrl holds pointers, sram_cnt, inflight, and the SRAM port logic.

Test Plan (DEPTH=4, DATA_WIDTH=8):
1. Latency: single enq 0xA5 at cycle 0 -> mem_wr_enable=1 with addr 0 in cycle 0; mem_rd_enable=1 with addr 0 in cycle 1; deq_valid=1 with deq_bits=0xA5 in cycle 3.
2. Fill: enq 7 entries 0x01..0x07 with deq_ready=0 -> count reaches 7; enq_ready=0 after the 7th; an 8th enq_valid is not accepted.
3. Drain/wrap: after test 2, deq_ready=1 while enqueuing 0x08..0x0F -> output 0x01..0x0F strictly in order, no gaps once streaming; wr_ptr/rd_ptr wrap 3->0 at least twice.
4. Throughput: enq_valid=deq_ready=1 for 20 cycles -> after 3-cycle fill, deq_fire every cycle; count constant at 3.
5. Flush: 5 entries held and a read in flight, assert flush one cycle -> next cycle count=0, deq_valid=0; the stale mem_rd_dataOut is not presented; a subsequent enq 0x3C dequeues as 0x3C.
6. Async reset: assert reset mid-stream between edges -> deq_valid, count and mem_*_enable go 0 immediately; after release, normal operation with empty FIFO.
